regfile: RTL and testbench

- Architectural register file with ROB renaming; sits between the decoder/dispatch and the reorder buffer.
- Holds 32 committed values plus, per register, a busy bit and the ROB tag of its newest in-flight producer.
- Answers operand lookups for the instruction being issued, forwarding through the ROB's search ports when the producer is still in flight.
- Absorbs commit writes and drops all renaming state on a misprediction clear.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_operand.sv | 26 ++
 rtl/regfile.sv | 71 +++++++
 tb/tb_regfile.sv | 138 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared ROB sizing constants and ROB entry type encodings
package regfile_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int ROB_SIZE = 2 ** ROB_WIDTH;
  localparam int REG_NUM = 32;
  typedef enum logic [1:0] {BR, ST, JALR, RG} rob_type_t;
endpackage

// File: rtl/regfile_operand.sv
// regfile_operand: one source lookup (rs, busy/tag/value of rs, commit bypass, ROB search result) -> ready, val
module regfile_operand
  import regfile_pkg::*;
#(
  parameter int RW = ROB_WIDTH
) (
  input  logic [4:0]    rs,
  input  logic          busy,
  input  logic [RW-1:0] tag,
  input  logic [31:0]   reg_val,
  input  logic          commit_ready,
  input  logic [RW-1:0] commit_rob_id,
  input  logic [31:0]   commit_val,
  input  logic          search_ready,
  input  logic [31:0]   search_val,
  output logic          ready,
  output logic [31:0]   val
);
  logic zero, byp;
  always_comb begin
    zero = rs == 5'd0;
    byp = commit_ready && commit_rob_id == tag;
    ready = zero || !busy || byp || search_ready;
    val = zero ? 32'd0 : !busy ? reg_val : byp ? commit_val : search_val;
  end
endmodule

// File: rtl/regfile.sv
// regfile: renamed register file (clk_in, async active-low rst_in, rdy_in stall, clear flush, dec_* issue, rs*_ lookups, search_* ROB ports, commit_* writes)
module regfile
  import regfile_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [ROB_W-1:0] dec_rob_id,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic [ROB_W-1:0] rs1_tag,
  output logic [ROB_W-1:0] rs2_tag,
  output logic [ROB_W-1:0] search_rob_id_1,
  output logic [ROB_W-1:0] search_rob_id_2,
  input  logic             search_ready_1,
  input  logic             search_ready_2,
  input  logic [31:0]      search_val_1,
  input  logic [31:0]      search_val_2,
  input  logic             commit_ready,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [4:0]       commit_reg_id,
  input  logic [31:0]      commit_val
);
  logic [31:0]      regs [REG_NUM];
  logic [ROB_W-1:0] tags [REG_NUM];
  logic [REG_NUM-1:0] busy;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_ready && commit_reg_id != 5'd0) begin
        regs[commit_reg_id] <= commit_val;
        if (tags[commit_reg_id] == commit_rob_id) busy[commit_reg_id] <= 1'b0;
      end
      if (clear) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) tags[i] <= '0;
      end else if (dec_ready && dec_rd != 5'd0) begin
        busy[dec_rd] <= 1'b1;
        tags[dec_rd] <= dec_rob_id;
      end
    end
  end
  assign rs1_tag = tags[dec_rs1];
  assign rs2_tag = tags[dec_rs2];
  assign search_rob_id_1 = tags[dec_rs1];
  assign search_rob_id_2 = tags[dec_rs2];
  regfile_operand #(.RW(ROB_W)) u_rs1 (
    .rs(dec_rs1), .busy(busy[dec_rs1]), .tag(tags[dec_rs1]), .reg_val(regs[dec_rs1]),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id), .commit_val(commit_val),
    .search_ready(search_ready_1), .search_val(search_val_1), .ready(rs1_ready), .val(rs1_val)
  );
  regfile_operand #(.RW(ROB_W)) u_rs2 (
    .rs(dec_rs2), .busy(busy[dec_rs2]), .tag(tags[dec_rs2]), .reg_val(regs[dec_rs2]),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id), .commit_val(commit_val),
    .search_ready(search_ready_2), .search_val(search_val_2), .ready(rs2_ready), .val(rs2_val)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
  logic clk_in = 0, rst_in = 0, rdy_in = 1, clear = 0, dec_ready = 0;
  logic [4:0] dec_rd = 0, dec_rs1 = 0, dec_rs2 = 0, commit_reg_id = 0;
  logic [3:0] dec_rob_id = 0, commit_rob_id = 0;
  logic rs1_ready, rs2_ready, search_ready_1 = 0, search_ready_2 = 0, commit_ready = 0;
  logic [31:0] rs1_val, rs2_val, search_val_1 = 0, search_val_2 = 0, commit_val = 0;
  logic [3:0] rs1_tag, rs2_tag, search_rob_id_1, search_rob_id_2;
  int n_checks = 0, n_fail = 0;
  regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic look(input logic [4:0] a, input logic [4:0] b);
    dec_rs1 = a;
    dec_rs2 = b;
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [3:0] id);
    dec_ready = 1; dec_rd = rd; dec_rob_id = id;
    tick();
    dec_ready = 0;
  endtask
  task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
    commit_ready = 1; commit_reg_id = rd; commit_rob_id = id; commit_val = v;
    tick();
    commit_ready = 0;
  endtask
  initial begin
    look(5, 0);
    check("rst_rs1_ready", rs1_ready, 1);
    check("rst_rs1_val", rs1_val, 0);
    #10 rst_in = 1;
    tick();
    look(5, 0);
    check("init_rs1_ready", rs1_ready, 1);
    check("init_rs1_val", rs1_val, 0);
    check("init_rs2_ready", rs2_ready, 1);
    check("init_rs2_val", rs2_val, 0);
    issue(3, 2);
    look(3, 0);
    check("busy_rs1_ready", rs1_ready, 0);
    check("busy_rs1_tag", rs1_tag, 2);
    check("busy_search_id", search_rob_id_1, 2);
    search_ready_1 = 1; search_val_1 = 32'h1234; #1;
    check("fwd_rs1_ready", rs1_ready, 1);
    check("fwd_rs1_val", rs1_val, 32'h1234);
    search_ready_1 = 0; search_val_1 = 0;
    issue(3, 5);
    commit(3, 2, 7);
    look(3, 0);
    check("old_commit_ready", rs1_ready, 0);
    check("old_commit_tag", rs1_tag, 5);
    commit_ready = 1; commit_reg_id = 3; commit_rob_id = 5; commit_val = 9; #1;
    check("byp3_ready", rs1_ready, 1);
    check("byp3_val", rs1_val, 9);
    tick();
    commit_ready = 0;
    look(3, 0);
    check("new_commit_ready", rs1_ready, 1);
    check("new_commit_val", rs1_val, 9);
    issue(4, 1);
    look(0, 4);
    commit_ready = 1; commit_reg_id = 4; commit_rob_id = 1; commit_val = 32'hAA;
    dec_ready = 1; dec_rd = 4; dec_rob_id = 6; #1;
    check("byp4_ready", rs2_ready, 1);
    check("byp4_val", rs2_val, 32'hAA);
    tick();
    commit_ready = 0; dec_ready = 0; #1;
    check("same_rd_ready", rs2_ready, 0);
    check("same_rd_tag", rs2_tag, 6);
    commit(7, 0, 32'h77);
    issue(7, 3);
    look(7, 0);
    check("r7_busy", rs1_ready, 0);
    check("r7_tag", rs1_tag, 3);
    clear = 1; dec_ready = 1; dec_rd = 8; dec_rob_id = 4;
    commit_ready = 1; commit_reg_id = 10; commit_rob_id = 9; commit_val = 32'h55;
    tick();
    clear = 0; dec_ready = 0; commit_ready = 0;
    look(7, 8);
    check("clr_r7_ready", rs1_ready, 1);
    check("clr_r7_val", rs1_val, 32'h77);
    check("clr_r7_tag", rs1_tag, 0);
    check("clr_r8_ready", rs2_ready, 1);
    check("clr_r8_tag", rs2_tag, 0);
    look(10, 4);
    check("clr_commit_val", rs1_val, 32'h55);
    check("clr_r4_ready", rs2_ready, 1);
    check("clr_r4_val", rs2_val, 32'hAA);
    issue(0, 7);
    commit(0, 0, 32'hDEAD);
    look(0, 0);
    check("x0_ready", rs1_ready, 1);
    check("x0_val", rs1_val, 0);
    check("x0_tag", rs1_tag, 0);
    rdy_in = 0;
    dec_ready = 1; dec_rd = 9; dec_rob_id = 2;
    commit_ready = 1; commit_reg_id = 9; commit_rob_id = 0; commit_val = 32'h99;
    tick();
    dec_ready = 0; commit_ready = 0; rdy_in = 1;
    look(9, 0);
    check("stall_ready", rs1_ready, 1);
    check("stall_val", rs1_val, 0);
    check("stall_tag", rs1_tag, 0);
    issue(11, 5);
    look(11, 10);
    check("pre_rst_busy", rs1_ready, 0);
    rst_in = 0; #1;
    check("async_rst_ready", rs1_ready, 1);
    check("async_rst_tag", rs1_tag, 0);
    check("async_rst_val", rs2_val, 0);
    rst_in = 1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
